whack_hit_scorer: RTL

Upstream scoring stage for the Whack game's score display. Converts raw active-low push-button presses into synchronized press events, judges each against the hole currently holding a mole, and maintains a saturating two-digit BCD score. The BCD digits feed the 7-segment point display directly; hit and miss pulses go to the game controller.

---
 rtl/whack_hit_scorer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/whack_hit_scorer.sv
// whack_hit_scorer
// Turns raw active-low button presses into synchronized press events,
// judges each event against the hole currently holding the mole and keeps
// a saturating two-digit BCD score for the 7-segment display.
//
// Pulse protocol: hit_pulse and miss_pulse are single-cycle, registered,
// mutually exclusive strobes with no back-pressure; the game controller
// must accept them in the cycle they are high.
//
// state_dbg mirrors the registered FSM state (0 = IDLE, 1 = WAIT,
// 2 = ARMED) so checkers can observe it without reaching into the design.
module whack_hit_scorer #(
    parameter int NUM_HOLES   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic [NUM_HOLES-1:0] KEY,
    input  logic [NUM_HOLES-1:0] mole_onehot,
    input  logic                 mole_new,
    input  logic                 game_active,
    input  logic                 clear_score,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [3:0]           score_ones,
    output logic [3:0]           score_tens,
    output logic                 score_max,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    localparam int SYNC_W = SYNC_STAGES * NUM_HOLES;

    state_t               state_q, state_d;
    logic [SYNC_W-1:0]    sync_q;
    logic [NUM_HOLES-1:0] synced;
    logic [NUM_HOLES-1:0] key_prev;
    logic [SYNC_STAGES:0] boot_q;
    logic                 events_ok;
    logic [NUM_HOLES-1:0] press_ev;
    logic                 hit_d, miss_d, inc;
    logic [3:0]           ones_d, tens_d;
    logic                 max_d;

    // Newest sample enters at the low slice, the oldest stage sits at the top.
    assign synced = sync_q[SYNC_W-1 -: NUM_HOLES];

    // After reset the synchronizer still holds the forced "released" value.
    // A button held through reset would show up as a falling edge once the
    // chain fills with the real level, so events stay masked until the
    // chain and key_prev both carry genuinely sampled values.
    assign events_ok = boot_q[SYNC_STAGES];
    assign press_ev  = events_ok ? (key_prev & ~synced) : '0;

    assign state_dbg = state_q;

    // Button synchronizer chain, previous-sample register and post-reset mask.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= '1;
            key_prev <= '1;
            boot_q   <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_W-NUM_HOLES-1:0], KEY};
            key_prev <= synced;
            boot_q   <= {boot_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Next-state and pulse decisions; at most one pulse per cycle, hit first.
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        inc     = 1'b0;
        if (!game_active) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            state_d = S_WAIT;
        end else if (mole_new) begin
            // A new appearance re-arms scoring; same-cycle presses are dropped.
            state_d = S_ARMED;
        end else if (state_q == S_ARMED) begin
            if (|(press_ev & mole_onehot)) begin
                hit_d   = 1'b1;
                inc     = 1'b1;
                state_d = S_WAIT;
            end else if (|press_ev) begin
                miss_d = 1'b1;
            end
        end else begin
            if (|press_ev) begin
                miss_d = 1'b1;
            end
        end
    end

    // Saturating BCD increment; clear_score overrides a same-cycle increment.
    always_comb begin
        ones_d = score_ones;
        tens_d = score_tens;
        if (clear_score) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc && !(score_ones == 4'd9 && score_tens == 4'd9)) begin
            if (score_ones == 4'd9) begin
                ones_d = 4'd0;
                tens_d = score_tens + 4'd1;
            end else begin
                ones_d = score_ones + 4'd1;
            end
        end
        max_d = (tens_d == 4'd9) && (ones_d == 4'd9);
    end

    // FSM state, output pulses and score registers.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            score_ones <= 4'd0;
            score_tens <= 4'd0;
            score_max  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_pulse  <= hit_d;
            miss_pulse <= miss_d;
            score_ones <= ones_d;
            score_tens <= tens_d;
            score_max  <= max_d;
        end
    end

endmodule
